// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl: byte-stream master that loads N/M/E into the RSA coprocessor, starts it and streams back the result.
// Optional WAIT-state timeout is compiled in when RSA_HOST_TIMEOUT_EN is defined.
module rsa_host_ctrl #(
   parameter int BYTES       = 32,
   parameter int START_CYC   = 2,
   parameter int GUARD_CYC   = 2,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       co_we,
   output logic       co_oe,
   output logic       co_start,
   output logic [1:0] co_reg_sel,
   output logic [4:0] co_addr,
   output logic [7:0] co_wdata,
   input  logic [7:0] co_rdata,
   input  logic       co_ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {LOAD, START, WAIT, RD_REQ, RD_CAP, OUT} state_t;

   state_t     state;
   logic [6:0] bc;
   logic [4:0] rc;
   logic [7:0] cnt;
   logic       accept;

`ifdef RSA_HOST_TIMEOUT_EN
   logic [16:0] tcnt;
`else
   assign err = 1'b0;
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= LOAD;
         bc         <= '0;
         rc         <= '0;
         cnt        <= '0;
         in_ready   <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         co_we      <= 1'b1;
         co_oe      <= 1'b1;
         co_start   <= 1'b1;
         co_reg_sel <= '0;
         co_addr    <= '0;
         co_wdata   <= '0;
`ifdef RSA_HOST_TIMEOUT_EN
         tcnt       <= '0;
         err        <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               // one write strobe per accepted byte, so back-to-back accepts keep co_we low
               co_we    <= ~accept;
               in_ready <= 1'b1;
               if (accept) begin
                  co_wdata   <= in_data;
                  co_addr    <= 5'(bc % 7'(BYTES));
                  co_reg_sel <= (bc < 7'(BYTES))     ? 2'd3 :
                                (bc < 7'(2 * BYTES)) ? 2'd1 : 2'd2;
                  busy       <= 1'b1;
`ifdef RSA_HOST_TIMEOUT_EN
                  err        <= 1'b0;
`endif
                  if (bc == 7'(3 * BYTES - 1)) begin
                     bc       <= '0;
                     in_ready <= 1'b0;
                     state    <= START;
                  end else begin
                     bc <= bc + 7'd1;
                  end
               end
            end
            START: begin
               co_we <= 1'b1;
               if (cnt < 8'(START_CYC)) begin
                  co_start <= 1'b0;
                  cnt      <= cnt + 8'd1;
               end else begin
                  co_start <= 1'b1;
                  cnt      <= '0;
                  state    <= WAIT;
`ifdef RSA_HOST_TIMEOUT_EN
                  tcnt     <= '0;
`endif
               end
            end
            WAIT: begin
               // co_ready may still show the pre-start idle level right after start release
               if (cnt < 8'(GUARD_CYC)) begin
                  cnt <= cnt + 8'd1;
               end else if (co_ready) begin
                  cnt        <= '0;
                  co_reg_sel <= 2'd0;
                  co_addr    <= rc;
                  co_oe      <= 1'b0;
                  state      <= RD_REQ;
               end
`ifdef RSA_HOST_TIMEOUT_EN
               if (tcnt == 17'(TIMEOUT_CYC - 1)) begin
                  err      <= 1'b1;
                  co_oe    <= 1'b1;
                  co_we    <= 1'b1;
                  co_start <= 1'b1;
                  cnt      <= '0;
                  bc       <= '0;
                  rc       <= '0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= LOAD;
               end else begin
                  tcnt <= tcnt + 17'd1;
               end
`endif
            end
            RD_REQ: begin
               co_oe <= 1'b1;
               state <= RD_CAP;
            end
            RD_CAP: begin
               out_data  <= co_rdata;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (rc == 5'(BYTES - 1)) begin
                     rc       <= '0;
                     busy     <= 1'b0;
                     in_ready <= 1'b1;
                     state    <= LOAD;
                  end else begin
                     rc         <= rc + 5'd1;
                     co_reg_sel <= 2'd0;
                     co_addr    <= rc + 5'd1;
                     co_oe      <= 1'b0;
                     state      <= RD_REQ;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
